// File: rtl/cgra_config_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the CGRA configuration bus: address field layout,
// reserved addresses and the decoded beat category.
package cgra_config_pkg;

   localparam int CFG_TILE_LSB = 0;
   localparam int CFG_TILE_W   = 16;
   localparam int CFG_FEAT_LSB = 16;
   localparam int CFG_FEAT_W   = 8;
   localparam int CFG_REG_LSB  = 24;
   localparam int CFG_REG_W    = 8;

   localparam logic [31:0] CFG_ADDR_IDLE   = 32'h0000_0000;
   localparam logic [31:0] CFG_ADDR_COMMIT = 32'hFFFF_FFFF;

   // Field view of a configuration address ("reg" is a keyword, hence regnum).
   typedef struct packed {
      logic [CFG_REG_W-1:0]  regnum;
      logic [CFG_FEAT_W-1:0] feature;
      logic [CFG_TILE_W-1:0] tile;
   } cfg_addr_t;

   // One-hot decode of a single beat.
   typedef struct packed {
      logic idle;
      logic commit;
      logic wr;
      logic rd;
      logic err;
      logic foreign;
   } cfg_dec_t;

endpackage

// File: rtl/cfg_addr_decode.sv
`timescale 1ns/1ps
// Combinational classifier for one registered configuration beat.
module cfg_addr_decode
   import cgra_config_pkg::*;
#(
   parameter logic [15:0] TILE_ID    = 16'h0001,
   parameter logic [7:0]  FEATURE_ID = 8'h00,
   parameter int          NUM_REGS   = 8
) (
   input  logic [31:0] addr,
   input  logic        rd,
   output cfg_dec_t    dec
);

   cfg_addr_t fields;

   assign fields.regnum  = addr[CFG_REG_LSB  +: CFG_REG_W];
   assign fields.feature = addr[CFG_FEAT_LSB +: CFG_FEAT_W];
   assign fields.tile    = addr[CFG_TILE_LSB +: CFG_TILE_W];

   // Reserved addresses win first; then own-tile beats are split into
   // valid register accesses and errors; everything else is foreign.
   always_comb begin
      dec = '0;
      if (addr == CFG_ADDR_IDLE) begin
         dec.idle = 1'b1;
      end else if (addr == CFG_ADDR_COMMIT) begin
         dec.commit = 1'b1;
      end else if (fields.tile == TILE_ID) begin
         if ((fields.feature == FEATURE_ID) &&
             ({24'd0, fields.regnum} < 32'(NUM_REGS))) begin
            dec.wr = !rd;
            dec.rd = rd;
         end else begin
            dec.err = 1'b1;
         end
      end else begin
         dec.foreign = 1'b1;
      end
   end

endmodule

// File: rtl/tile_config_endpoint.sv
`timescale 1ns/1ps
// Per-tile configuration bus endpoint: registers each beat, decodes it, and
// maintains shadow/active register banks, readback and an error counter.
module tile_config_endpoint
   import cgra_config_pkg::*;
#(
   parameter logic [15:0] TILE_ID     = 16'h0001,
   parameter logic [7:0]  FEATURE_ID  = 8'h00,
   parameter int          NUM_REGS    = 8,
   parameter logic [31:0] RESET_VALUE = 32'h0
) (
   input  logic                     clk_in,
   input  logic                     reset_in,
   input  logic [31:0]              config_addr_in,
   input  logic [31:0]              config_data_in,
   input  logic                     config_read_in,
   output logic [NUM_REGS*32-1:0]   cfg_regs_out,
   output logic [31:0]              config_rdata_out,
   output logic                     config_rdata_valid_out,
   output logic                     commit_pulse_out,
   output logic [7:0]               err_count_out
);

   logic [31:0]          addr_p1;
   logic [31:0]          data_p1;
   logic                 rd_p1;
   cfg_dec_t             dec_p1;
   logic [CFG_REG_W-1:0] reg_idx_p1;
   logic [31:0]          shadow_rd_p1;
   logic                 shadow_we_p1;
   logic                 commit_en_p1;
   logic                 rd_en_p1;
   logic                 err_en_p1;

   logic [31:0] shadow [NUM_REGS];
   logic [31:0] active [NUM_REGS];

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      if (v == 8'hFF) return v;
      return v + 8'd1;
   endfunction

   // ---- S1: capture every beat unconditionally ----
   // Input beat register.
   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         addr_p1 <= '0;
         data_p1 <= '0;
         rd_p1   <= 1'b0;
      end else begin
         addr_p1 <= config_addr_in;
         data_p1 <= config_data_in;
         rd_p1   <= config_read_in;
      end
   end

   // ---- S2: decode and act on the S1 beat ----
   cfg_addr_decode #(
      .TILE_ID    (TILE_ID),
      .FEATURE_ID (FEATURE_ID),
      .NUM_REGS   (NUM_REGS)
   ) u_decode (
      .addr (addr_p1),
      .rd   (rd_p1),
      .dec  (dec_p1)
   );

   assign reg_idx_p1 = addr_p1[CFG_REG_LSB +: CFG_REG_W];

   // Turn the one-hot decode into per-action enables.
   always_comb begin
      shadow_we_p1 = 1'b0;
      commit_en_p1 = 1'b0;
      rd_en_p1     = 1'b0;
      err_en_p1    = 1'b0;
      unique case (1'b1)
         dec_p1.commit:  commit_en_p1 = 1'b1;
         dec_p1.wr:      shadow_we_p1 = 1'b1;
         dec_p1.rd:      rd_en_p1     = 1'b1;
         dec_p1.err:     err_en_p1    = 1'b1;
         dec_p1.idle,
         dec_p1.foreign: ;
         default:        ;
      endcase
   end

   // Shadow readback mux; index is already range-checked by the decoder.
   always_comb begin
      shadow_rd_p1 = '0;
      for (int k = 0; k < NUM_REGS; k++) begin
         if (reg_idx_p1 == 8'(k)) shadow_rd_p1 = shadow[k];
      end
   end

   // Shadow writes and atomic shadow-to-active copy on commit.
   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         for (int k = 0; k < NUM_REGS; k++) begin
            shadow[k] <= RESET_VALUE;
            active[k] <= RESET_VALUE;
         end
      end else begin
         for (int k = 0; k < NUM_REGS; k++) begin
            if (shadow_we_p1 && (reg_idx_p1 == 8'(k))) shadow[k] <= data_p1;
            if (commit_en_p1) active[k] <= shadow[k];
         end
      end
   end

   // Readback capture, commit strobe and saturating error count.
   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         config_rdata_out       <= '0;
         config_rdata_valid_out <= 1'b0;
         commit_pulse_out       <= 1'b0;
         err_count_out          <= '0;
      end else begin
         config_rdata_valid_out <= rd_en_p1;
         commit_pulse_out       <= commit_en_p1;
         if (rd_en_p1)  config_rdata_out <= shadow_rd_p1;
         if (err_en_p1) err_count_out    <= sat_inc(err_count_out);
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
      assign cfg_regs_out[32*g +: 32] = active[g];
   end

endmodule

// File: tb/tb_tile_config_endpoint.sv
`timescale 1ns/1ps
// Directed bench for tile_config_endpoint with a queue-based scoreboard for
// readback and commit responses.
module tb_tile_config_endpoint;

   localparam logic [31:0] COMMIT = 32'hFFFF_FFFF;

   logic         clk = 1'b0;
   logic         reset_in;
   logic [31:0]  addr;
   logic [31:0]  data;
   logic         rd;
   logic [255:0] regs;
   logic [31:0]  rdata;
   logic         rvld;
   logic         pulse;
   logic [7:0]   err;

   always #5 clk = ~clk;

   tile_config_endpoint #(
      .TILE_ID     (16'h0001),
      .FEATURE_ID  (8'h00),
      .NUM_REGS    (8),
      .RESET_VALUE (32'h0)
   ) dut (
      .clk_in                 (clk),
      .reset_in               (reset_in),
      .config_addr_in         (addr),
      .config_data_in         (data),
      .config_read_in         (rd),
      .cfg_regs_out           (regs),
      .config_rdata_out       (rdata),
      .config_rdata_valid_out (rvld),
      .commit_pulse_out       (pulse),
      .err_count_out          (err)
   );

   typedef struct {
      bit           is_commit;
      logic [31:0]  rdata;
      logic [255:0] regs;
      logic [7:0]   err;
      int           cyc;
   } exp_t;

   exp_t q[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] mk(input logic [7:0] r, input logic [7:0] f,
                                      input logic [15:0] t);
      return {r, f, t};
   endfunction

   // Drive one beat; returns the index of the edge that samples it.
   task automatic beat(input logic [31:0] a, input logic [31:0] d, input logic r,
                       output int e0);
      addr = a; data = d; rd = r;
      @(posedge clk);
      #1;
      e0 = cyc;
   endtask

   task automatic idle(input int n);
      int e;
      for (int i = 0; i < n; i++) beat(32'h0, 32'h0, 1'b0, e);
   endtask

   task automatic expect_read(input logic [31:0] d, input int c);
      exp_t e;
      e.is_commit = 1'b0; e.rdata = d; e.regs = '0; e.err = '0; e.cyc = c;
      q.push_back(e);
   endtask

   task automatic expect_commit(input logic [255:0] r, input logic [7:0] ec, input int c);
      exp_t e;
      e.is_commit = 1'b1; e.rdata = '0; e.regs = r; e.err = ec; e.cyc = c;
      q.push_back(e);
   endtask

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Monitor: every response pulse must match the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rvld || pulse) begin
         vectors++;
         if (q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_output: cyc=%0d rvld=%b pulse=%b rdata=%h err=%0d",
                     cyc, rvld, pulse, rdata, err);
         end else begin
            e = q.pop_front();
            if (e.is_commit) begin
               if (!(pulse === 1'b1 && rvld === 1'b0 && regs === e.regs &&
                     err === e.err && cyc == e.cyc)) begin
                  miscompares++;
                  $display("FAIL commit: cyc=%0d pulse=%b rvld=%b regs=%h err=%0d expected cyc=%0d regs=%h err=%0d",
                           cyc, pulse, rvld, regs, err, e.cyc, e.regs, e.err);
               end
            end else begin
               if (!(rvld === 1'b1 && pulse === 1'b0 && rdata === e.rdata && cyc == e.cyc)) begin
                  miscompares++;
                  $display("FAIL readback: cyc=%0d rvld=%b pulse=%b rdata=%h expected cyc=%0d rdata=%h",
                           cyc, rvld, pulse, rdata, e.cyc, e.rdata);
               end
            end
         end
      end
   end

   initial begin
      logic [255:0] exp_regs;
      int           e0;

      reset_in = 1'b0; addr = '0; data = '0; rd = 1'b0;
      exp_regs = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_regs", regs, 256'h0);
      check("reset_rdata", 256'(rdata), 256'h0);
      check("reset_rvld", 256'(rvld), 256'h0);
      check("reset_pulse", 256'(pulse), 256'h0);
      check("reset_err", 256'(err), 256'h0);
      reset_in = 1'b1;

      // Write alone leaves the active bank untouched.
      beat(mk(8'h02, 8'h00, 16'h0001), 32'hDEAD_BEEF, 1'b0, e0);
      idle(3);
      check("write_no_commit", regs, 256'h0);

      // Commit publishes reg 2 only.
      beat(COMMIT, 32'h0, 1'b0, e0);
      exp_regs[2*32 +: 32] = 32'hDEAD_BEEF;
      expect_commit(exp_regs, 8'd0, e0 + 1);
      idle(3);
      check("regs_after_commit", regs, exp_regs);

      // Write then immediate read of the same register.
      beat(mk(8'h05, 8'h00, 16'h0001), 32'h0000_1234, 1'b0, e0);
      beat(mk(8'h05, 8'h00, 16'h0001), 32'h0, 1'b1, e0);
      expect_read(32'h0000_1234, e0 + 1);
      idle(3);
      check("rdata_hold", 256'(rdata), 256'h1234);
      check("rvld_low_after", 256'(rvld), 256'h0);

      // Commit carrying the read flag, then back-to-back commits.
      exp_regs[5*32 +: 32] = 32'h0000_1234;
      beat(COMMIT, 32'h0, 1'b1, e0);
      expect_commit(exp_regs, 8'd0, e0 + 1);
      beat(COMMIT, 32'h0, 1'b0, e0);
      expect_commit(exp_regs, 8'd0, e0 + 1);
      beat(COMMIT, 32'h0, 1'b0, e0);
      expect_commit(exp_regs, 8'd0, e0 + 1);
      idle(2);

      // Out-of-range register.
      beat(mk(8'h08, 8'h00, 16'h0001), 32'h5555_5555, 1'b0, e0);
      beat(COMMIT, 32'h0, 1'b0, e0);
      expect_commit(exp_regs, 8'd1, e0 + 1);
      // Wrong feature.
      beat(mk(8'h01, 8'h01, 16'h0001), 32'h6666_6666, 1'b0, e0);
      beat(COMMIT, 32'h0, 1'b0, e0);
      expect_commit(exp_regs, 8'd2, e0 + 1);
      // Foreign tile.
      beat(mk(8'h01, 8'h00, 16'h0002), 32'h7777_7777, 1'b0, e0);
      beat(COMMIT, 32'h0, 1'b0, e0);
      expect_commit(exp_regs, 8'd2, e0 + 1);
      // Error read and foreign read produce no readback.
      beat(mk(8'h09, 8'h00, 16'h0001), 32'h0, 1'b1, e0);
      beat(mk(8'h01, 8'h00, 16'h0002), 32'h0, 1'b1, e0);
      beat(COMMIT, 32'h0, 1'b0, e0);
      expect_commit(exp_regs, 8'd3, e0 + 1);
      idle(3);
      check("rdata_after_err_read", 256'(rdata), 256'h1234);

      // Error counter saturation.
      for (int i = 0; i < 251; i++)
         beat(mk(8'(8 + (i % 200)), 8'h00, 16'h0001), 32'(i), 1'b0, e0);
      idle(3);
      check("err_254", 256'(err), 256'd254);
      for (int i = 0; i < 300; i++)
         beat(mk(8'(8 + (i % 240)), 8'h00, 16'h0001), 32'(i), 1'b0, e0);
      idle(3);
      check("err_saturated", 256'(err), 256'hFF);
      beat(COMMIT, 32'h0, 1'b0, e0);
      expect_commit(exp_regs, 8'hFF, e0 + 1);
      idle(3);

      // Reset pulse in the middle of a write stream.
      beat(mk(8'h00, 8'h00, 16'h0001), 32'hA0A0_A0A0, 1'b0, e0);
      beat(mk(8'h01, 8'h00, 16'h0001), 32'hB1B1_B1B1, 1'b0, e0);
      beat(mk(8'h02, 8'h00, 16'h0001), 32'hC2C2_C2C2, 1'b0, e0);
      beat(mk(8'h03, 8'h00, 16'h0001), 32'hD3D3_D3D3, 1'b0, e0);
      reset_in = 1'b0;
      #0.5;
      check("midreset_regs", regs, 256'h0);
      check("midreset_rdata", 256'(rdata), 256'h0);
      check("midreset_err", 256'(err), 256'h0);
      check("midreset_pulse", 256'(pulse), 256'h0);
      #0.5;
      reset_in = 1'b1;
      beat(COMMIT, 32'h0, 1'b0, e0);
      expect_commit(256'h0, 8'd0, e0 + 1);
      idle(3);
      check("post_reset_regs", regs, 256'h0);
      check("post_reset_rdata", 256'(rdata), 256'h0);

      // Bounded drain of outstanding expectations.
      for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
      vectors++;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: %0d responses outstanding, expected 0", q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/tile_config_endpoint.md
# tile_config_endpoint

Per-tile receiver for the CGRA configuration bus: the fabric-side end of the 32-bit address/data stream that the system bench and host driver push into `top` once per clock. It registers each address/data beat and decodes the tile, feature and register fields. Matching writes land in a shadow register bank, which a broadcast commit copies atomically into the active bank driving the tile datapath. It also provides single-beat readback and a saturating count of decode errors.

## Interface
- `TILE_ID`, 16'h0001: this tile's ID; must be nonzero, and 16'hFFFF is reserved.
- `FEATURE_ID`, 8'h00: feature field this endpoint responds to.
- `NUM_REGS`, 8: number of 32-bit config registers; range 1..255.
- `RESET_VALUE`, 32'h0: reset/initial value of every shadow and active register.
- `clk_in` input 1: sole clock. All state updates on its rising edge.
- `reset_in` input 1: asynchronous, active-low reset.
- `config_addr_in` input 32: fields are [31:24] reg, [23:16] feature, [15:0] tile. Value 0 means idle.
- `config_data_in` input 32: write data, sampled together with the address.
- `config_read_in` input 1: 1 marks the beat as a read (data ignored); 0 marks a write.
- `cfg_regs_out` output NUM_REGS*32: active bank, flattened; reg k sits at [32k+31:32k].
- `config_rdata_out` output 32: readback data.
- `config_rdata_valid_out` output 1: one-cycle pulse qualifying `config_rdata_out`.
- `commit_pulse_out` output 1: one-cycle pulse in the cycle the active bank updates.
- `err_count_out` output 8: saturating decode-error count.

## Operation
- Stage S1 registers addr, data and read flag every cycle unconditionally. S1 contents reset to 0.
- Stage S2 decodes the S1 contents. All decode categories are mutually exclusive, one beat per cycle:
  - Idle: addr == 0. No action.
  - Commit: addr == 32'hFFFF_FFFF, any read flag. All shadow registers copy to active. `commit_pulse_out` = 1.
  - Match write: tile == TILE_ID, feature == FEATURE_ID, reg < NUM_REGS, read = 0. shadow[reg] <= data. Active bank unchanged.
  - Match read: same field match, read = 1. `config_rdata_out` <= shadow[reg]; `config_rdata_valid_out` <= 1.
  - Error: tile == TILE_ID but feature mismatches, or reg >= NUM_REGS. No register update; `err_count_out` increments, saturating at 8'hFF. An error read returns no valid pulse.
  - Foreign: any other tile. Ignored silently.
- `config_rdata_out` holds its last value when not valid. It is never cleared except by reset.
- Beats are processed strictly in order. A write at S2 in cycle N is visible to a read or commit reaching S2 in cycle N+1.
- There is no backpressure: the endpoint accepts one beat per cycle, always.

## Timing
- Beat sampled at edge E0 (enters S1). Shadow write, readback capture and commit all take effect at edge E1.
  - Readback latency is therefore 2 edges: `config_rdata_valid_out` is high for exactly the cycle after E1.
  - `cfg_regs_out` changes only at a commit edge. It is glitch-free because it is driven directly from flops.
- Reset assertion, at any time including mid-stream:
  - S1 is cleared; any beat in S1 is discarded.
  - Shadow and active registers go to RESET_VALUE.
  - `config_rdata_out` = 0, `config_rdata_valid_out` = 0, `commit_pulse_out` = 0, `err_count_out` = 0.
- After deassertion, the first beat presented is accepted at the next rising edge.
- A commit with no prior writes is legal. It rewrites active with the current shadow and still pulses.
- Back-to-back commits pulse `commit_pulse_out` on consecutive cycles.

## Structure
- Shared package `cgra_config_pkg` holds the common definitions:
  - Field positions: CFG_TILE_LSB=0, CFG_FEAT_LSB=16, CFG_REG_LSB=24, each with its width.
  - CFG_ADDR_IDLE = 32'h0 and CFG_ADDR_COMMIT = 32'hFFFF_FFFF.
  - A packed struct `cfg_addr_t` {reg, feature, tile}.
- A single sub-module `cfg_addr_decode` handles decoding: it is combinational, takes the S1 address, read flag and parameters, and returns a one-hot {idle, commit, wr, rd, err, foreign}.
- The register banks are flop arrays in the top module; no RAM macro is used.

## Test plan
- Reset, then write 32'hDEAD_BEEF to addr {8'h02, 8'h00, 16'h0001}. Check `cfg_regs_out` reg 2 is still 0, i.e. the active bank is unchanged by a write.
- Same write, then one commit beat 32'hFFFF_FFFF. Check `commit_pulse_out` pulses one cycle and reg 2 = 32'hDEAD_BEEF, while regs 0..1 and 3..7 stay 0.
- Write 32'h1234 to reg 5, then on the next cycle read reg 5. Check `config_rdata_valid_out` pulses exactly 2 edges after the read beat with `config_rdata_out` = 32'h1234.
- Errors and foreign beats, each followed by a commit:
  - Write to reg 8 (NUM_REGS=8): `err_count_out` = 1.
  - Write to feature 8'h01: `err_count_out` = 2.
  - Write to tile 16'h0002: ignored; `err_count_out` stays 2.
  - `cfg_regs_out` unchanged in every case.
- Drive 300 consecutive error beats: `err_count_out` saturates at 8'hFF.
- Stream 4 writes, then assert `reset_in` low for 1 ns mid-stream and commit afterwards: all registers remain RESET_VALUE, and the outputs hold the reset values throughout.
